// File: rtl/result_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_ser_pkg
// Description : Shared types, default sizes and the parity helper for the
//               result serializer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package result_ser_pkg;

    localparam int W_DEF          = 12;
    localparam int DEPTH_DEF      = 4;
    localparam int BIT_CYC_DEF    = 4;
    localparam int FRAME_BITS_DEF = W_DEF + 3;

    // Serial framer states: start bit, data bits, parity bit, stop bit
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ser_state_e;

    // Even parity over a zero-extended word (XOR of all bits)
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Synchronous FIFO with extra-bit wrapping pointers. The head
//               entry is presented combinationally on dout; full/empty are
//               decoded from the registered pointers only.
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    // Pointer advance; the caller never pushes into a full FIFO without a pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers, cleared on reset (which also discards the contents)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; when full with a simultaneous pop the freed head slot is reused
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : result_serializer
// Description : Captures strobed results into a FIFO and ships each one as a
//               framed (start, MSB-first data, even parity, stop) serial word
//               on a registered line. Counts results lost to overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module result_serializer
    import result_ser_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int BIT_CYC = BIT_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] y_in,
    input  logic         y_vld,
    output logic         tx,
    output logic         busy,
    output logic         empty,
    output logic         full,
    output logic [7:0]   drop_cnt
);

    localparam int BCW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int DCW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CYC - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(W - 1);

    ser_state_e     state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0] data_cnt_q, data_cnt_d;
    logic [W-1:0]   shift_q, shift_d;
    logic           par_q, par_d;
    logic           tx_q, tx_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic [W-1:0]   fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           drop;
    logic           bit_last;

    result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (y_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write acceptance: a pop in the same cycle frees a slot even when full
    always_comb begin
        fifo_push  = y_vld && (!fifo_full || fifo_pop);
        drop       = y_vld && fifo_full && !fifo_pop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Framer next-state, counters, shift register and next line value
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        fifo_pop   = 1'b0;
        bit_last   = (bit_cnt_q == BIT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
                    par_d      = even_parity(32'(fifo_head));
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    data_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    bit_cnt_d = '0;
                    if (data_cnt_q == DATA_LAST) begin
                        state_d    = ST_PARITY;
                        data_cnt_d = '0;
                    end else begin
                        shift_d    = {shift_q[W-2:0], 1'b0};
                        data_cnt_d = data_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    bit_cnt_d  = '0;
                    data_cnt_d = '0;
                    // Chain straight into the next frame when work is queued
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        par_d    = even_parity(32'(fifo_head));
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = '0;
                data_cnt_d = '0;
            end
        endcase

        // Line value follows the state being entered so tx aligns with state_q
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[W-1];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign empty    = fifo_empty;
    assign full     = fifo_full;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_serializer
// Description : Scoreboard bench. The stimulus side keeps an abstract model
//               (queue of buffered words plus remaining frame cycles) and
//               pushes the expected frames; a line monitor decodes tx and
//               compares each frame against the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_serializer;

    localparam int W         = 12;
    localparam int DEPTH     = 4;
    localparam int BIT_CYC   = 4;
    localparam int FRAME_CYC = (W + 3) * BIT_CYC;

    typedef struct {
        logic [W-1:0] word;
        int           start;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] y_in;
    logic         y_vld;
    logic         tx;
    logic         busy;
    logic         empty;
    logic         full;
    logic [7:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] mq [$];
    exp_t         sb [$];
    int           rem   = 0;
    int           mdrop = 0;
    int           cyc   = 0;

    // Monitor state
    int           mon_idx = -1;
    int           mon_start;
    logic         samp [FRAME_CYC];

    result_serializer #(
        .W       (W),
        .DEPTH   (DEPTH),
        .BIT_CYC (BIT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .y_in     (y_in),
        .y_vld    (y_vld),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then check status outputs
    task automatic step(input logic v, input logic [W-1:0] d);
        int   sz;
        logic pop;
        logic acc;
        exp_t e;
        y_vld = v;
        y_in  = d;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            rem   = 0;
            mdrop = 0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && (rem <= 1);
            acc = v && ((sz < DEPTH) || pop);
            if (pop) begin
                e.word  = mq.pop_front();
                e.start = cyc;
                sb.push_back(e);
                rem = FRAME_CYC;
            end else if (rem > 0) begin
                rem--;
            end
            if (acc) mq.push_back(d);
            else if (v && mdrop < 255) mdrop++;
        end
        #1;
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("busy", int'(busy), int'(rem > 0));
        chk("drop_cnt", int'(drop_cnt), mdrop);
        if (rem == 0) chk("tx_idle", int'(tx), 1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step(1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (mq.size() == 0 && rem == 0 && sb.size() == 0 && mon_idx < 0) break;
            step(1'b0, '0);
        end
        chk("drain_complete", int'(mq.size() == 0 && rem == 0 && sb.size() == 0 && mon_idx < 0), 1);
    endtask

    // Decode one complete 60-cycle frame captured from the line
    task automatic check_frame();
        logic         glitch;
        logic [W-1:0] word;
        logic         par;
        exp_t         e;
        glitch = 1'b0;
        for (int b = 0; b < W + 3; b++) begin
            for (int c = 1; c < BIT_CYC; c++) begin
                if (samp[b*BIT_CYC + c] !== samp[b*BIT_CYC]) glitch = 1'b1;
            end
        end
        for (int i = 0; i < W; i++) word[W-1-i] = samp[(1 + i) * BIT_CYC];
        par = samp[(W + 1) * BIT_CYC];
        chk("bit_stable", int'(glitch), 0);
        chk("stop_bit", int'(samp[(W + 2) * BIT_CYC]), 1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0h expected=none", word);
        end else begin
            e = sb.pop_front();
            chk("frame_data", int'(word), int'(e.word));
            chk("frame_start_cycle", mon_start, e.start);
            chk("parity_bit", int'(par), int'($countones(e.word) % 2));
        end
    endtask

    // Line monitor: hunt for a start bit, then capture one sample per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_idx = -1;
            end else if (mon_idx < 0) begin
                if (tx === 1'b0) begin
                    mon_start = cyc;
                    samp[0]   = 1'b0;
                    mon_idx   = 1;
                end
            end else begin
                samp[mon_idx] = tx;
                mon_idx++;
                if (mon_idx == FRAME_CYC) begin
                    check_frame();
                    mon_idx = -1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pct;
        rst_n = 1'b0;
        y_vld = 1'b0;
        y_in  = '0;

        // Reset then idle
        do_reset(3);
        chk("reset_tx", int'(tx), 1);
        chk("reset_drop", int'(drop_cnt), 0);
        repeat (20) step(1'b0, '0);

        // Single words, including both parity polarities
        step(1'b1, 12'hA5C);
        drain();
        step(1'b1, 12'h001);
        drain();
        step(1'b1, 12'hFFF);
        drain();

        // Three consecutive strobes: back-to-back frames
        step(1'b1, 12'h111);
        step(1'b1, 12'h222);
        step(1'b1, 12'h333);
        drain();

        // Seven consecutive strobes from idle: five sent, two dropped
        do_reset(2);
        for (int i = 0; i < 7; i++) step(1'b1, 12'(16 * i + 12'h0A1));
        chk("burst_full", int'(full), 1);
        chk("burst_drops", int'(drop_cnt), 2);
        drain();

        // Reset in the middle of the data bits aborts the frame
        step(1'b1, 12'h5A3);
        repeat (15) step(1'b0, '0);
        chk("mid_frame_busy", int'(busy), 1);
        rst_n = 1'b0;
        step(1'b0, '0);
        chk("tx_after_reset", int'(tx), 1);
        chk("empty_after_reset", int'(empty), 1);
        rst_n = 1'b1;
        step(1'b0, '0);
        step(1'b1, 12'h3C7);
        drain();

        // Randomised traffic: sparse, then heavy (drop saturation), then sparse
        for (int seg = 0; seg < 3; seg++) begin
            pct = (seg == 1) ? 60 : 4;
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 99) < pct), W'($urandom_range(0, 4095)));
            end
        end
        chk("drop_saturated", int'(drop_cnt), 255);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the arithmetic top module: captures each qualified 12-bit result `y` on a strobe, buffers it in a small FIFO, and ships it off-chip as a framed, parity-protected, MSB-first serial word on a single line. It decouples the result rate from the slow serial link and counts results lost to overflow.

## Interface
- `W`, 12, result width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `BIT_CYC`, 4, clock cycles per serial bit; ≥ 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `y_in`  in  W  result word from the top module.
- `y_vld`  in  1  capture strobe; `y_in` is sampled on every edge where it is high.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress (any state except IDLE).
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `drop_cnt`  out  8  results discarded on overflow, saturating.

## Operation
- Frame: start bit 0, W data bits MSB first, 1 even-parity bit (XOR of all data bits), stop bit 1; FRAME_BITS = W+3 = 15.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1; if FIFO not empty, pop head into shift register, go to START.
  - START: `tx`=0 for BIT_CYC cycles, then DATA.
  - DATA: `tx`=shift MSB; shift left every BIT_CYC cycles; after W bits, go to PARITY.
  - PARITY: `tx`=parity for BIT_CYC cycles, then STOP.
  - STOP: `tx`=1 for BIT_CYC cycles; on the last cycle, if FIFO not empty, pop and go straight to START (no idle gap), else go to IDLE.
- Bit-cycle counter runs 0..BIT_CYC-1. Data-bit counter runs 0..W-1. Both clear on every state change.
- Write: `y_vld`=1 and not full → push. `y_vld`=1 and full → word discarded, `drop_cnt` += 1, saturating at 255.
- Simultaneous push and pop when full: pop frees the slot, push accepted, no drop, `full` stays 1.
- Simultaneous push and pop when empty: impossible, because a pop requires not-empty in the same cycle.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. `full`/`empty` are derived from the pointers and are registered-equivalent; there is no combinational path from `y_vld`.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `drop_cnt`=0, FSM=IDLE, pointers=0.
- Reset asserted mid-frame aborts the frame. `tx` returns to 1 at the next edge and FIFO contents are lost.
- `tx` is driven straight from a register; it never glitches.
- Latency: `y_vld` sampled at edge k → `empty` falls after k → pop at edge k+1 → `tx` falls after edge k+1 (start bit). This assumes FSM was in IDLE.
- Frame duration: 15·BIT_CYC cycles = 60 cycles by default.
- Back-to-back frames: stop bit of frame n is immediately followed by start bit of frame n+1.
- `busy` rises with the START entry and falls on the edge that returns the FSM to IDLE.

## Structure
- Package `result_ser_pkg`: FSM state enum, default W/FRAME_BITS constants, parity function.
- Sub-module `result_fifo`: synchronous FIFO parameterised by W/DEPTH, with push/pop/full/empty ports. The serializer FSM, counters and drop counter live in the top `result_serializer`.

## Test plan
- Reset then idle: `tx`=1, `empty`=1, `drop_cnt`=0 for 20 cycles with no strobe.
- Single word `y_in`=0xA5C, one-cycle strobe: `tx` falls 1 cycle after the sampling edge. Line sequence (each bit 4 cycles) is 0, 101001011100, 0 (parity), 1. `busy` is high for exactly 60 cycles.
- Word 0x001: parity bit = 1. Word 0xFFF: parity bit = 0.
- Strobe 3 words (0x111, 0x222, 0x333) on consecutive cycles: three frames back-to-back with no idle cycles. `empty` returns to 1 after the third pop.
- Strobe 7 consecutive words while idle: 1 is popped immediately and 4 are buffered (`full`=1), so 2 are dropped and `drop_cnt`=2. Only the first 5 words appear on `tx`, in order.
- Assert `rst_n`=0 mid-DATA of a frame: `tx`=1 on the next edge, and `busy`=0, `empty`=1 thereafter. A new strobe after release is transmitted normally.
